dm_responder: RTL and testbench

Slave end of the CPU data-memory port. It accepts the core's cs/oe/web/addr/datain requests and returns dm_dataout combinationally in the same cycle, so the MEM stage can capture load data at the next edge. It backs a 12288-word byte-writable RAM and a 3-word MMIO window at the top of the 14-bit word space. The window holds a free-running cycle counter and a console output FIFO drained by an external valid/ready consumer.

---
 rtl/dm_responder.sv | 189 ++++++++++++++++++
 tb/tb_dm_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: slave end of the CPU data-memory port.
//
// Backs a 12288-word byte-writable RAM and a small MMIO window at 14'h3000.
// CNT (14'h3000) is a free-running cycle counter, TX (14'h3001) pushes into a
// console FIFO, and STAT (14'h3002) reports FIFO state and a sticky overflow flag.
// An external valid/ready consumer drains the console FIFO.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset (clears MMIO state only)
//   dm_cs, dm_oe   chip select / output enable
//   dm_web         active-low byte write enables, bit i gates bits 8i+7:8i
//   dm_addr        14-bit word address
//   dm_datain      write data
//   dm_dataout     combinational read data (0 unless cs & oe)
//   out_valid      console FIFO head valid
//   out_data       console FIFO head word
//   out_ready      consumer accepts the head when out_valid & out_ready
module dm_responder #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dm_cs,
    input  logic                 dm_oe,
    input  logic [3:0]           dm_web,
    input  logic [13:0]          dm_addr,
    input  logic [DATA_SIZE-1:0] dm_datain,
    output logic [DATA_SIZE-1:0] dm_dataout,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data,
    input  logic                 out_ready
);

    localparam int unsigned RamWords = 12288;
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW     = PtrW + 1;

    localparam logic [13:0] AddrCnt  = 14'h3000;
    localparam logic [13:0] AddrTx   = 14'h3001;
    localparam logic [13:0] AddrStat = 14'h3002;

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    logic sel_ram, sel_cnt, sel_tx, sel_stat;
    logic full_wr;

    always_comb begin
        sel_ram  = (dm_addr[13:12] != 2'b11);
        sel_cnt  = (dm_addr == AddrCnt);
        sel_tx   = (dm_addr == AddrTx);
        sel_stat = (dm_addr == AddrStat);
        // MMIO registers only react to whole-word writes.
        full_wr  = dm_cs && (dm_web == 4'b0000);
    end

    // ---------------------------------------------------------------------
    // RAM (not reset; reset still blocks writes so it dominates everything)
    // ---------------------------------------------------------------------
    logic [DATA_SIZE-1:0] ram_q [RamWords];

    always_ff @(posedge clk) begin
        if (!rst && dm_cs && sel_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (!dm_web[i]) begin
                    ram_q[dm_addr][8*i +: 8] <= dm_datain[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Cycle counter
    // ---------------------------------------------------------------------
    logic [DATA_SIZE-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (full_wr && sel_cnt) begin
            cnt_d = dm_datain;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Console FIFO
    // ---------------------------------------------------------------------
    logic [DATA_SIZE-1:0] fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 empty, full, pop, push_req, push, drop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CntW'(FIFO_DEPTH));
        pop      = !empty && out_ready;
        push_req = full_wr && sel_tx;
        // A pop in the same cycle frees the slot the push lands in.
        push     = push_req && (!full || pop);
        drop     = push_req && !push;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // STAT clear and an overflowing push never share an address, so the
        // clear can simply take priority.
        ovf_d = ovf_q || drop;
        if (full_wr && sel_stat) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entries are cleared on reset so out_data reads 0 afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= dm_datain;
        end
    end

    always_comb begin
        out_valid = !empty;
        out_data  = fifo_q[rd_ptr_q];
    end

    // ---------------------------------------------------------------------
    // Read path
    // ---------------------------------------------------------------------
    logic [DATA_SIZE-1:0] stat_word;

    always_comb begin
        stat_word             = '0;
        stat_word[CntW-1:0]   = count_q;
        stat_word[8]          = empty;
        stat_word[9]          = full;
        stat_word[16]         = ovf_q;

        dm_dataout = '0;
        if (dm_cs && dm_oe) begin
            if (sel_ram) begin
                dm_dataout = ram_q[dm_addr];
            end else if (sel_cnt) begin
                dm_dataout = cnt_q;
            end else if (sel_stat) begin
                dm_dataout = stat_word;
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    localparam int unsigned Depth = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dm_cs, dm_oe;
    logic [3:0]  dm_web;
    logic [13:0] dm_addr;
    logic [31:0] dm_datain;
    logic [31:0] dm_dataout;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    dm_responder #(
        .DATA_SIZE (32),
        .FIFO_DEPTH(Depth)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dm_cs     (dm_cs),
        .dm_oe     (dm_oe),
        .dm_web    (dm_web),
        .dm_addr   (dm_addr),
        .dm_datain (dm_datain),
        .dm_dataout(dm_dataout),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] ram_m [12288];
    logic [31:0] cnt_m;
    int          count_m;
    bit          ovf_m;
    logic [13:0] pool [64];

    // Scoreboards
    typedef struct {
        logic [31:0] dout;
        logic        valid;
    } cyc_t;
    cyc_t        cyc_q[$];
    logic [31:0] tx_exp[$];

    int n_vec = 0;
    int n_err = 0;

    // Monitor: per-cycle read data / out_valid, plus drained words on handshake.
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            cyc_t e;
            e = cyc_q.pop_front();
            n_vec++;
            if (dm_dataout !== e.dout) begin
                n_err++;
                $display("FAIL dataout addr=%h got=%h exp=%h", dm_addr, dm_dataout, e.dout);
            end
            n_vec++;
            if (out_valid !== e.valid) begin
                n_err++;
                $display("FAIL out_valid got=%b exp=%b", out_valid, e.valid);
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            if (tx_exp.size() == 0) begin
                n_err++;
                $display("FAIL tx_unexpected got=%h exp=none", out_data);
            end else begin
                logic [31:0] w;
                w = tx_exp.pop_front();
                if (out_data !== w) begin
                    n_err++;
                    $display("FAIL tx_data got=%h exp=%h", out_data, w);
                end
            end
        end
    end

    // Drive one cycle, predict its outputs, then advance the model past the edge.
    task automatic step(input bit cs, input bit oe, input logic [3:0] web,
                        input logic [13:0] addr, input logic [31:0] din,
                        input bit ready, input bit r);
        cyc_t        e;
        logic [31:0] stat;
        bit          full_wr, pop;
        int          cnt_before;
        dm_cs     = cs;
        dm_oe     = oe;
        dm_web    = web;
        dm_addr   = addr;
        dm_datain = din;
        out_ready = ready;
        rst       = r;

        stat = 32'(count_m);
        if (count_m == 0)     stat = stat + 32'h100;
        if (count_m == Depth) stat = stat + 32'h200;
        if (ovf_m)            stat = stat + 32'h10000;

        e.dout = 32'h0;
        if (cs && oe) begin
            if (addr < 14'd12288)        e.dout = ram_m[addr];
            else if (addr == 14'h3000)   e.dout = cnt_m;
            else if (addr == 14'h3002)   e.dout = stat;
        end
        e.valid = (count_m != 0);
        cyc_q.push_back(e);

        if (r) begin
            cnt_m   = 32'h0;
            count_m = 0;
            ovf_m   = 0;
            tx_exp.delete();
        end else begin
            full_wr = cs && (web == 4'b0000);
            if (cs && addr < 14'd12288) begin
                for (int i = 0; i < 4; i++) begin
                    if (!web[i]) ram_m[addr][8*i +: 8] = din[8*i +: 8];
                end
            end
            if (full_wr && addr == 14'h3000) cnt_m = din;
            else cnt_m = cnt_m + 32'd1;
            cnt_before = count_m;
            pop = (count_m != 0) && ready;
            if (pop) count_m--;
            if (full_wr && addr == 14'h3001) begin
                if (cnt_before < Depth || pop) begin
                    tx_exp.push_back(din);
                    count_m++;
                end else begin
                    ovf_m = 1;
                end
            end
            if (full_wr && addr == 14'h3002) ovf_m = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [13:0] addr);
        step(1, 1, 4'hF, addr, 32'h0, 0, 0);
    endtask

    initial begin
        logic [13:0] a;
        logic [3:0]  w;
        bit          r;
        int          sel;

        rst = 1'b1; dm_cs = 0; dm_oe = 0; dm_web = 4'hF; dm_addr = '0;
        dm_datain = '0; out_ready = 0;
        cnt_m = 0; count_m = 0; ovf_m = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and counter from reset: reads in cycles 0..5.
        for (int i = 0; i < 6; i++) rd(14'h3000);
        rd(14'h3002);

        // RAM full and partial writes, same-cycle read returns old data, oe=0.
        step(1, 0, 4'b0000, 14'h0010, 32'hDEADBEEF, 0, 0);
        rd(14'h0010);
        step(1, 1, 4'b1110, 14'h0010, 32'h000000AA, 0, 0);
        rd(14'h0010);
        step(1, 0, 4'hF, 14'h0010, 32'h0, 0, 0);

        // Counter load and wrap; partial mask must not load.
        step(1, 0, 4'b0000, 14'h3000, 32'hFFFFFFFE, 0, 0);
        rd(14'h3000);
        rd(14'h3000);
        rd(14'h3000);
        step(1, 1, 4'b0111, 14'h3000, 32'h12345678, 0, 0);
        rd(14'h3000);

        // Fill FIFO, overflow, clear.
        for (int i = 1; i <= 4; i++) step(1, 0, 4'b0000, 14'h3001, 32'(i), 0, 0);
        rd(14'h3002);
        step(1, 0, 4'b0000, 14'h3001, 32'd5, 0, 0);
        rd(14'h3002);
        step(1, 0, 4'b0000, 14'h3002, 32'h0, 0, 0);
        rd(14'h3002);

        // Push into full FIFO while popping, then drain.
        step(1, 0, 4'b0000, 14'h3001, 32'd9, 1, 0);
        rd(14'h3002);
        for (int i = 0; i < 4; i++) step(0, 0, 4'hF, 14'h0, 32'h0, 1, 0);
        rd(14'h3002);

        // Mid-stream reset loses undrained data but keeps RAM.
        step(1, 0, 4'b0000, 14'h3001, 32'd7, 0, 0);
        step(0, 0, 4'hF, 14'h0, 32'h0, 0, 1);
        rd(14'h3002);
        rd(14'h0010);
        rd(14'h3000);

        // cs=0 writes do nothing.
        step(0, 1, 4'b0000, 14'h0010, 32'h11111111, 0, 0);
        step(0, 1, 4'b0000, 14'h3001, 32'h22222222, 0, 0);
        rd(14'h0010);
        rd(14'h3002);

        // Seed a pool of RAM words for the random phase.
        for (int i = 0; i < 64; i++) begin
            pool[i] = (i < 32) ? 14'(i) : 14'(12288 - 64 + i);
            step(1, 0, 4'b0000, pool[i], $urandom, 0, 0);
        end

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4)      a = pool[$urandom_range(0, 63)];
            else if (sel == 5) a = 14'h3000;
            else if (sel <= 7) a = 14'h3001;
            else if (sel == 8) a = 14'h3002;
            else               a = 14'h3003 + 14'($urandom_range(0, 4092));
            w = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom);
            r = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, w, a, $urandom,
                 r ? 1'b0 : 1'($urandom_range(0, 1)), r);
        end

        // Drain whatever remains.
        for (int i = 0; i < Depth + 2; i++) step(0, 0, 4'hF, 14'h0, 32'h0, 1, 0);
        rd(14'h3002);
        @(negedge clk);
        #1;
        n_vec++;
        if (tx_exp.size() != 0) begin
            n_err++;
            $display("FAIL tx_leftover got=%0d words pending exp=0", tx_exp.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
